// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
// Bundles every bus signal around the data-memory arbiter: the CPU
// load/store port, the debug/loader port and the single-ported data memory.
//
//   cpu_req/we/addr/wdata  : CPU request fields (requester -> arbiter)
//   cpu_ack/err/rdata      : CPU completion (arbiter -> requester)
//   dbg_*                  : same set for the debug/loader port
//   mem_write/read/addr/wdata : memory strobes and buses (arbiter -> memory)
//   mem_rdata              : combinational read data (memory -> arbiter)
//
// Modports:
//   master : requester/memory side (drives requests and mem_rdata)
//   slave  : the arbiter itself
interface dmem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ack;
    logic        cpu_err;
    logic [31:0] cpu_rdata;

    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic        dbg_err;
    logic [31:0] dbg_rdata;

    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_err, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_err, dbg_rdata,
        input  mem_write, mem_read, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_err, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_err, dbg_rdata,
        output mem_write, mem_read, mem_addr, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Round-robin arbiter and access sequencer in front of a single-ported
// data memory (synchronous write, combinational read). Each access takes
// three cycles: IDLE (arbitrate + latch), ACCESS (range/alignment check and
// one memory strobe), DONE (one-cycle ack/err pulse to the granted port).
//
// Ports:
//   clk        : clock, all state on the rising edge
//   rst        : synchronous active-high reset
//   bus        : dmem_arbiter_if.slave (CPU port, debug port, memory side)
//   err_count  : saturating count of rejected accesses
//
// Parameters:
//   ADDR_WORDS_LOG2 : log2 of memory depth in 32-bit words
//   ERR_CNT_W       : width of err_count
module dmem_arbiter #(
    parameter int ADDR_WORDS_LOG2 = 8,
    parameter int ERR_CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_arbiter_if.slave        bus,
    output logic [ERR_CNT_W-1:0] err_count
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Port index: 0 = CPU, 1 = DBG.
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    state_t                state_reg;
    state_t                state_next;
    logic                  gnt_reg;
    logic                  last_grant_reg;
    logic                  we_reg;
    logic [31:0]           addr_reg;
    logic [31:0]           wdata_reg;
    logic                  err_reg;
    logic [ERR_CNT_W-1:0]  err_count_reg;

    logic                  take;
    logic                  pick_dbg;
    logic                  bad;
    logic [1:0]            ack_vec;
    logic [1:0]            err_vec;

    // Misaligned, or any address bit above the memory's byte range set.
    assign bad = (addr_reg[1:0] != 2'b00) ||
                 (addr_reg[31:ADDR_WORDS_LOG2+2] != '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state, arbitration decision and memory-side outputs.
    always_comb begin
        state_next    = state_reg;
        take          = 1'b0;
        pick_dbg      = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state_reg)
            IDLE: begin
                if (bus.cpu_req || bus.dbg_req) begin
                    take = 1'b1;
                    // On a tie the port that was not served last wins.
                    if (bus.cpu_req && bus.dbg_req) begin
                        pick_dbg = (last_grant_reg == PORT_CPU);
                    end else begin
                        pick_dbg = bus.dbg_req;
                    end
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                state_next = DONE;
                if (!bad) begin
                    bus.mem_addr  = addr_reg;
                    bus.mem_wdata = wdata_reg;
                    // Strobes are killed by reset so a pending access
                    // cannot commit in the cycle it is being dropped.
                    bus.mem_write = we_reg && !rst;
                    bus.mem_read  = !we_reg && !rst;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Latched request fields, grant history and error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_reg        <= PORT_CPU;
            last_grant_reg <= PORT_DBG;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            err_reg        <= 1'b0;
            err_count_reg  <= '0;
        end else begin
            if (take) begin
                gnt_reg   <= pick_dbg;
                we_reg    <= pick_dbg ? bus.dbg_we    : bus.cpu_we;
                addr_reg  <= pick_dbg ? bus.dbg_addr  : bus.cpu_addr;
                wdata_reg <= pick_dbg ? bus.dbg_wdata : bus.cpu_wdata;
            end
            if (state_reg == ACCESS) begin
                last_grant_reg <= gnt_reg;
                err_reg        <= bad;
                if (bad && (err_count_reg != '1)) begin
                    err_count_reg <= err_count_reg + ERR_CNT_W'(1);
                end
            end
        end
    end

    // Per-port completion pulses and read-data holding registers. A port's
    // rdata only changes at its own completion: load data, or 0 for a store
    // or a rejected access.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            logic [31:0] rdata_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_reg <= '0;
                end else if ((state_reg == ACCESS) && (gnt_reg == 1'(gi))) begin
                    rdata_reg <= (bad || we_reg) ? '0 : bus.mem_rdata;
                end
            end

            assign ack_vec[gi] = (state_reg == DONE) && (gnt_reg == 1'(gi)) && !rst;
            assign err_vec[gi] = ack_vec[gi] && err_reg;
        end
    endgenerate

    assign bus.cpu_ack   = ack_vec[0];
    assign bus.dbg_ack   = ack_vec[1];
    assign bus.cpu_err   = err_vec[0];
    assign bus.dbg_err   = err_vec[1];
    assign bus.cpu_rdata = g_port[0].rdata_reg;
    assign bus.dbg_rdata = g_port[1].rdata_reg;
    assign err_count     = err_count_reg;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter. A 256-word memory sits on the
// memory side; a transaction-level reference model (word array, grant
// history, error count, per-port rdata) predicts the order of service,
// ack timing, strobes and returned data for each scenario.
module tb_dmem_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] err_count;

    dmem_arbiter_if bus();

    dmem_arbiter #(
        .ADDR_WORDS_LOG2(8),
        .ERR_CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Data memory: synchronous write, combinational read.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [31:0] ref_mem [0:255];
    bit          ref_last_dbg;
    int          ref_err;
    logic [31:0] ref_rdata [2];

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          is_bad;
        logic [31:0] exp_rdata;
    } acc_t;

    function automatic acc_t mk(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        acc_t a;
        a.port = 1'b0;
        a.we = we;
        a.addr = addr;
        a.wdata = wdata;
        a.is_bad = 1'b0;
        a.exp_rdata = '0;
        return a;
    endfunction

    // Apply one access to the model in service order.
    task automatic model_access(inout acc_t a);
        a.is_bad = (a.addr % 4 != 0) || (a.addr >= 32'd1024);
        if (a.is_bad) begin
            a.exp_rdata = '0;
            if (ref_err < 255) ref_err++;
        end else if (a.we) begin
            ref_mem[a.addr[9:2]] = a.wdata;
            a.exp_rdata = '0;
        end else begin
            a.exp_rdata = ref_mem[a.addr[9:2]];
        end
        ref_rdata[a.port] = a.exp_rdata;
        ref_last_dbg = a.port;
    endtask

    task automatic drive_port(input bit p, input bit req, input bit we,
                              input logic [31:0] addr, input logic [31:0] wdata);
        if (!p) begin
            bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        end else begin
            bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wdata;
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        drive_port(0, 0, 0, '0, '0);
        drive_port(1, 0, 0, '0, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ref_last_dbg = 1'b1;
        ref_err = 0;
        ref_rdata[0] = '0;
        ref_rdata[1] = '0;
    endtask

    // Issue up to one request per port in the same cycle and check every
    // following cycle until both have completed. Called and returns at a
    // falling edge.
    task automatic dual(input bit c_en, input acc_t c, input bit d_en, input acc_t d,
                        input string tag);
        acc_t seq[$];
        acc_t tmp;
        bit   first_dbg;
        int   n;
        first_dbg = (c_en && d_en) ? !ref_last_dbg : d_en;
        c.port = 1'b0;
        d.port = 1'b1;
        if (c_en) drive_port(0, 1, c.we, c.addr, c.wdata);
        if (d_en) drive_port(1, 1, d.we, d.addr, d.wdata);
        if (first_dbg) begin
            if (d_en) seq.push_back(d);
            if (c_en) seq.push_back(c);
        end else begin
            if (c_en) seq.push_back(c);
            if (d_en) seq.push_back(d);
        end
        n = seq.size();
        for (int k = 0; k < n; k++) begin
            tmp = seq[k];
            model_access(tmp);
            seq[k] = tmp;
        end
        for (int cyc = 1; cyc <= 3 * n + 1; cyc++) begin
            logic       exp_w;
            logic       exp_r;
            logic [1:0] exp_ack;
            logic [1:0] exp_err;
            int         k_acc;
            int         k_ack;
            logic [31:0] got_rd;
            @(negedge clk);
            exp_w = 1'b0; exp_r = 1'b0; exp_ack = 2'b00; exp_err = 2'b00;
            k_acc = -1; k_ack = -1;
            for (int k = 0; k < n; k++) begin
                if (cyc == 1 + 3 * k) k_acc = k;
                if (cyc == 2 + 3 * k) k_ack = k;
            end
            if (k_acc >= 0 && !seq[k_acc].is_bad) begin
                exp_w = seq[k_acc].we;
                exp_r = !seq[k_acc].we;
            end
            if (k_ack >= 0) begin
                exp_ack[seq[k_ack].port] = 1'b1;
                exp_err[seq[k_ack].port] = seq[k_ack].is_bad;
            end
            total++;
            if ({bus.mem_write, bus.mem_read} !== {exp_w, exp_r}) begin
                bad++;
                $display("FAIL %s strobes cyc %0d: got w=%b r=%b want w=%b r=%b",
                         tag, cyc, bus.mem_write, bus.mem_read, exp_w, exp_r);
            end
            if (exp_w || exp_r) begin
                total++;
                if (bus.mem_addr !== seq[k_acc].addr) begin
                    bad++;
                    $display("FAIL %s mem_addr cyc %0d: got %h want %h",
                             tag, cyc, bus.mem_addr, seq[k_acc].addr);
                end
            end
            if (exp_w) begin
                total++;
                if (bus.mem_wdata !== seq[k_acc].wdata) begin
                    bad++;
                    $display("FAIL %s mem_wdata cyc %0d: got %h want %h",
                             tag, cyc, bus.mem_wdata, seq[k_acc].wdata);
                end
            end
            total++;
            if ({bus.dbg_ack, bus.cpu_ack} !== exp_ack) begin
                bad++;
                $display("FAIL %s acks cyc %0d: got dbg/cpu=%b%b want %b",
                         tag, cyc, bus.dbg_ack, bus.cpu_ack, exp_ack);
            end
            total++;
            if ({bus.dbg_err, bus.cpu_err} !== exp_err) begin
                bad++;
                $display("FAIL %s errs cyc %0d: got dbg/cpu=%b%b want %b",
                         tag, cyc, bus.dbg_err, bus.cpu_err, exp_err);
            end
            if (k_ack >= 0) begin
                got_rd = seq[k_ack].port ? bus.dbg_rdata : bus.cpu_rdata;
                total++;
                if (got_rd !== seq[k_ack].exp_rdata) begin
                    bad++;
                    $display("FAIL %s rdata port %0d: got %h want %h",
                             tag, seq[k_ack].port, got_rd, seq[k_ack].exp_rdata);
                end
                drive_port(seq[k_ack].port, 0, 0, '0, '0);
            end
        end
        total++;
        if (err_count !== 8'(ref_err)) begin
            bad++;
            $display("FAIL %s err_count: got %0d want %0d", tag, err_count, ref_err);
        end
        total++;
        if (bus.cpu_rdata !== ref_rdata[0] || bus.dbg_rdata !== ref_rdata[1]) begin
            bad++;
            $display("FAIL %s held rdata: got cpu=%h dbg=%h want cpu=%h dbg=%h",
                     tag, bus.cpu_rdata, bus.dbg_rdata, ref_rdata[0], ref_rdata[1]);
        end
    endtask

    task automatic test_reset();
        reset_dut();
        total++;
        if ({bus.cpu_ack, bus.cpu_err, bus.dbg_ack, bus.dbg_err} !== 4'b0000) begin
            bad++;
            $display("FAIL reset acks/errs: got %b%b%b%b want 0000",
                     bus.cpu_ack, bus.cpu_err, bus.dbg_ack, bus.dbg_err);
        end
        total++;
        if (bus.cpu_rdata !== 32'h0 || bus.dbg_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset rdata: got cpu=%h dbg=%h want 0", bus.cpu_rdata, bus.dbg_rdata);
        end
        total++;
        if ({bus.mem_write, bus.mem_read} !== 2'b00 || bus.mem_addr !== 32'h0 ||
            bus.mem_wdata !== 32'h0) begin
            bad++;
            $display("FAIL reset mem bus: got w=%b r=%b a=%h d=%h want 0",
                     bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata);
        end
        total++;
        if (err_count !== 8'd0) begin
            bad++;
            $display("FAIL reset err_count: got %0d want 0", err_count);
        end
    endtask

    task automatic test_store_load();
        dual(1, mk(1, 32'h10, 32'hDEADBEEF), 0, mk(0, 0, 0), "store_0x10");
        dual(1, mk(0, 32'h10, 32'h0), 0, mk(0, 0, 0), "load_0x10");
        total++;
        if (bus.cpu_rdata !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL store_load value: got %h want deadbeef", bus.cpu_rdata);
        end
    endtask

    // Both ports hold loads continuously; grants must alternate starting
    // with the port that did not go last.
    task automatic test_fairness();
        logic [31:0] fa [2];
        bit next_dbg;
        int grants;
        reset_dut();
        dual(0, mk(0, 0, 0), 1, mk(1, 32'h40, $urandom), "fair_pre0");
        dual(0, mk(0, 0, 0), 1, mk(1, 32'h44, $urandom), "fair_pre1");
        fa[0] = 32'h40;
        fa[1] = 32'h44;
        drive_port(0, 1, 0, fa[0], '0);
        drive_port(1, 1, 0, fa[1], '0);
        next_dbg = !ref_last_dbg;
        grants = 0;
        for (int cyc = 1; cyc <= 19; cyc++) begin
            logic [1:0] exp_ack;
            logic       exp_r;
            acc_t       t;
            logic [31:0] got_rd;
            logic [31:0] got_idle;
            @(negedge clk);
            exp_ack = 2'b00;
            exp_r = (cyc % 3 == 1) && ((cyc - 1) / 3 < 6);
            if (cyc % 3 == 2 && grants < 6) exp_ack[next_dbg] = 1'b1;
            total++;
            if ({bus.mem_write, bus.mem_read} !== {1'b0, exp_r}) begin
                bad++;
                $display("FAIL fairness strobes cyc %0d: got w=%b r=%b want w=0 r=%b",
                         cyc, bus.mem_write, bus.mem_read, exp_r);
            end
            total++;
            if ({bus.dbg_ack, bus.cpu_ack} !== exp_ack) begin
                bad++;
                $display("FAIL fairness acks cyc %0d: got dbg/cpu=%b%b want %b",
                         cyc, bus.dbg_ack, bus.cpu_ack, exp_ack);
            end
            if (exp_ack != 2'b00) begin
                t = mk(0, fa[next_dbg], '0);
                t.port = next_dbg;
                model_access(t);
                got_rd   = next_dbg ? bus.dbg_rdata : bus.cpu_rdata;
                got_idle = next_dbg ? bus.cpu_rdata : bus.dbg_rdata;
                total++;
                if (got_rd !== t.exp_rdata) begin
                    bad++;
                    $display("FAIL fairness rdata grant %0d: got %h want %h",
                             grants, got_rd, t.exp_rdata);
                end
                total++;
                if (got_idle !== ref_rdata[!next_dbg]) begin
                    bad++;
                    $display("FAIL fairness idle rdata grant %0d: got %h want %h",
                             grants, got_idle, ref_rdata[!next_dbg]);
                end
                next_dbg = !next_dbg;
                grants++;
                if (grants == 6) begin
                    drive_port(0, 0, 0, '0, '0);
                    drive_port(1, 0, 0, '0, '0);
                end
            end
        end
    endtask

    task automatic test_errors();
        reset_dut();
        dual(1, mk(0, 32'h13, 0), 0, mk(0, 0, 0), "err_misaligned");
        dual(0, mk(0, 0, 0), 1, mk(1, 32'h400, 32'hBAD0BAD0), "err_range");
        total++;
        if (err_count !== 8'd2) begin
            bad++;
            $display("FAIL errors count: got %0d want 2", err_count);
        end
        dual(1, mk(0, 32'h0, 0), 0, mk(0, 0, 0), "err_word0");
    endtask

    task automatic test_reset_mid();
        reset_dut();
        drive_port(1, 1, 1, 32'h20, 32'hCAFEF00D);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (bus.mem_write !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid strobe: got mem_write=%b want 0", bus.mem_write);
        end
        drive_port(1, 0, 0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (bus.dbg_ack !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid ack cyc %0d: got dbg_ack=%b want 0", i, bus.dbg_ack);
            end
        end
        rst = 1'b0;
        ref_last_dbg = 1'b1;
        ref_err = 0;
        ref_rdata[0] = '0;
        ref_rdata[1] = '0;
        dual(1, mk(0, 32'h20, 0), 0, mk(0, 0, 0), "reset_mid_load");
        total++;
        if (bus.cpu_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid value: got %h want 0", bus.cpu_rdata);
        end
        dual(1, mk(0, 32'h20, 0), 1, mk(0, 32'h24, 0), "reset_mid_tie");
    endtask

    task automatic test_coherence();
        dual(1, mk(0, 32'h0, 0), 0, mk(0, 0, 0), "coh_pre");
        dual(1, mk(0, 32'h3FC, 0), 1, mk(1, 32'h3FC, 32'h12345678), "coherence");
        total++;
        if (bus.cpu_rdata !== 32'h12345678 || bus.dbg_rdata !== 32'h0) begin
            bad++;
            $display("FAIL coherence value: got cpu=%h dbg=%h want 12345678/0",
                     bus.cpu_rdata, bus.dbg_rdata);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int kind;
        kind = $urandom_range(0, 9);
        if (kind < 7) return {22'h0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'b00};
        if (kind == 7) return {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
        return $urandom | 32'h400;
    endfunction

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            int sel;
            sel = $urandom_range(0, 2);
            dual(sel != 1, mk(1'($urandom_range(0, 1)), rand_addr(), $urandom),
                 sel != 0, mk(1'($urandom_range(0, 1)), rand_addr(), $urandom), "random");
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 305; i++) begin
            logic [31:0] a;
            a = {22'h0, 8'($urandom_range(0, 255)), 2'b01};
            dual(1, mk(1'($urandom_range(0, 1)), a, $urandom), 0, mk(0, 0, 0), "saturate");
            if (i == 299) begin
                total++;
                if (err_count !== 8'd255) begin
                    bad++;
                    $display("FAIL saturation count: got %0d want 255", err_count);
                end
            end
        end
        total++;
        if (err_count !== 8'd255) begin
            bad++;
            $display("FAIL saturation hold: got %0d want 255", err_count);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        drive_port(0, 0, 0, '0, '0);
        drive_port(1, 0, 0, '0, '0);
        @(negedge clk);
        test_reset();
        test_store_load();
        test_fairness();
        test_errors();
        test_reset_mid();
        test_coherence();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-ported data memory (256 × 32-bit words, synchronous write, combinational read). It shares the memory between the CPU load/store port and a debug/loader port using round-robin arbitration and a request/acknowledge handshake. Every access is checked for alignment and range before reaching the memory. It sits between the MEM stage / debug loader and the data memory instance, and drives the memory's `mem_write`, `mem_read`, `addr` and `write_data` inputs.

## Interface

- `ADDR_WORDS_LOG2`, default 8: log2 of memory depth in words; valid byte addresses are 0 .. 4·2^ADDR_WORDS_LOG2 − 1.
- `ERR_CNT_W`, default 8: width of the saturating error counter.

- `clk` in 1: single clock, all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cpu_req` in 1: CPU request; held high until `cpu_ack`.
- `cpu_we` in 1: 1 = store, 0 = load; stable while `cpu_req` is high.
- `cpu_addr` in 32: byte address; stable while `cpu_req` is high.
- `cpu_wdata` in 32: store data.
- `cpu_ack` out 1: one-cycle completion pulse.
- `cpu_err` out 1: valid with `cpu_ack`; access rejected.
- `cpu_rdata` out 32: load data, valid with `cpu_ack`.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_ack`, `dbg_err`, `dbg_rdata`: identical semantics for the debug/loader port.
- `mem_write` out 1, `mem_read` out 1, `mem_addr` out 32, `mem_wdata` out 32: to the data memory.
- `mem_rdata` in 32: from the data memory.
- `err_count` out ERR_CNT_W: saturating count of rejected accesses.

## Operation

- FSM states: IDLE, ACCESS, DONE. Reset state is IDLE.
- IDLE: if no request, stay. If exactly one `*_req` is high, grant that port. If both are high, grant the port not equal to `last_grant`. Latch the granted port id, `we`, `addr` and `wdata`, then go to ACCESS. `last_grant` resets to DBG, so the CPU wins the first tie.
- ACCESS: compute `bad = (addr[1:0] != 0) | (addr[31:ADDR_WORDS_LOG2+2] != 0)`.
  - If `!bad`: drive `mem_addr = latched addr` and `mem_wdata = latched wdata`. Assert `mem_write = we` or `mem_read = !we`, for exactly this one cycle. Capture `mem_rdata` into the granted port's rdata register (loads only).
  - If `bad`: assert neither strobe, set the rdata register to 0, and set the error flag. Increment `err_count`, saturating at all-ones.
  - Update `last_grant` to the granted port. Go to DONE.
- DONE: pulse the granted port's `*_ack` (and `*_err` if `bad`), then go to IDLE.
- Memory outputs are combinational from state and latched registers.
  - `mem_write`, `mem_read`, `mem_addr` and `mem_wdata` are 0 outside ACCESS.
  - Both strobes are gated by `!rst`.
- `*_rdata` holds its value until that port's next completion.
  - On a store completion it is 0.
  - The other port's rdata is not disturbed.
- Requesters deassert `*_req` in the cycle after seeing `*_ack`. A request still high when the arbiter returns to IDLE is treated as a new access.
- A request that drops before its ack is a protocol violation. The arbiter has already latched its fields and completes the access regardless.

## Timing

- Reset values: `*_ack`, `*_err`, `*_rdata`, `mem_*` strobes/buses, `err_count` = 0; state IDLE; `last_grant` = DBG.
- Latency: request first seen high in IDLE at cycle T → memory access at T+1 → `*_ack` at T+2. Next arbitration is at T+3.
- Throughput: one access per 3 cycles. Under continuous requests from both ports, grants alternate CPU, DBG, CPU, …
- Store: the memory commits write data at the rising edge ending cycle T+1. A load from another port arbitrated afterwards observes the new value.
- Single requester: always granted, with no fairness penalty. `last_grant` still updates.
- Simultaneous events: a request arriving during ACCESS or DONE waits for IDLE. Only IDLE samples requests.
- Reset mid-operation: if `rst` is high during ACCESS, no memory strobe is asserted that cycle, no ack is issued, the state goes to IDLE, and the pending access is dropped.
- `err_count` does not wrap: at 2^ERR_CNT_W − 1 it holds.

## Test plan

- Single CPU store then load: store 0xDEADBEEF to 0x10, then load 0x10. `mem_write` is high for exactly one cycle with `mem_addr=0x10`. Each `cpu_ack` arrives 2 cycles after its req is sampled. The load returns `cpu_rdata=0xDEADBEEF`, `cpu_err=0`.
- Tie and fairness: both ports hold loads continuously for 6 grants. First grant goes to CPU, then strict alternation. Acks arrive every 3 cycles, and the idle port's rdata is unchanged.
- Errors: CPU load at 0x13 (misaligned), then DBG store at 0x400 (out of range). Both return ack with err=1 and rdata=0. No `mem_read`/`mem_write` strobe is asserted, and `err_count` reaches 2. Memory word 0 (aliased index) is unchanged.
- Saturation: 300 misaligned accesses → `err_count` = 255 and holds there.
- Reset mid-access: DBG store to 0x20 with `rst` asserted in its ACCESS cycle. `mem_write` stays 0 and no `dbg_ack` is issued. After reset, a load of 0x20 returns 0, and the next CPU/DBG tie goes to CPU.
- Cross-port coherence: DBG stores 0x12345678 to 0x3FC while CPU requests a load of 0x3FC in the same cycle, with `last_grant`=CPU so DBG wins. The DBG ack arrives first. The CPU load acks 3 cycles later with 0x12345678.
